fir_decim_requant: RTL and testbench
====================================

// Module: fir_decim_requant
// PURPOSE
//  Downstream stage of the 63-tap FIR. Consumes the 20-bit filter output y every valid cycle.
//  Decimates by DECIM, requantises to OUT_W bits (shift, optional round, saturate) and buffers
//  results in a DEPTH-entry FIFO with a valid/ready output handshake toward the sink.
// PARAMETERS
//  IN_W     20  input width (signed two's complement, matches FIR y)
//  OUT_W    12  output width (signed)
//  SHIFT    8   LSBs discarded before saturation
//  DECIM    4   decimation factor, >=1 (1 = no decimation)
//  DEPTH    8   FIFO entries, power of 2, >=2
// PORTS
//  CLK       in   1                   rising-edge clock
//  RSTN      in   1                   async active-low reset
//  in_valid  in   1                   in_data valid this cycle
//  in_data   in   IN_W                FIR output sample (signed)
//  out_ready in   1                   sink accepts out_data this cycle
//  out_valid out  1                   FIFO non-empty
//  out_data  out  OUT_W               FIFO head (signed)
//  level     out  $clog2(DEPTH)+1     FIFO occupancy 0..DEPTH
//  drop      out  1                   sticky: a result was lost to a full FIFO
//  drop_clr  in   1                   clears drop
// BEHAVIOUR
//  - Reset (async, RSTN=0): phase=0, pipeline valid=0, FIFO empty, out_valid=0, level=0,
//    drop=0, out_data=0. Takes effect immediately, incl. mid-operation; FIFO contents discarded.
//  - Phase counter 0..DECIM-1 advances only on in_valid; wraps DECIM-1 -> 0.
//  - Sample taken when in_valid && phase==DECIM-1 (the DECIM-th, 2*DECIM-th... input after reset).
//  - Stage 1 (registered): q = in_data >>> SHIFT (arithmetic), with rounding per CONFIGURATION;
//    sum computed at IN_W+1 bits so no internal wrap. Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  - Stage 2: q written into FIFO on the next edge.
//  - Latency: decimated input sampled at edge N -> out_valid=1 with data after edge N+2
//    (FIFO empty). out_data is show-ahead: combinational read of head entry.
//  - Pop: out_valid && out_ready at an edge removes head. out_ready ignored when empty.
//  - Push when full: accepted if a pop occurs in the same cycle (level unchanged); otherwise
//    dropped, FIFO unchanged, drop set.
//  - Push+pop when empty: pop ignored (out_valid=0), push accepted, level=1.
//  - drop_clr and a new drop in same cycle: drop stays 1 (set wins).
//  - Pointers log2(DEPTH) bits, wrap naturally; level = registered count.
//  - No pipeline back-pressure to FIR: input side never stalls; overflow is only via drop.
// CONFIGURATION
//  FIR_DECIM_ROUND_EN defined: q = (in_data + 2^(SHIFT-1)) >>> SHIFT (round half up) then saturate.
//  Not defined: q = in_data >>> SHIFT (truncate toward -inf) then saturate. Same latency/area
//  otherwise. SHIFT=0 with macro defined: no rounding term added.
// TESTING (defaults: IN_W=20 OUT_W=12 SHIFT=8 DECIM=4 DEPTH=8)
//  1 Reset: RSTN=0 for 5 cycles, random inputs -> out_valid=0, level=0, drop=0, out_data=0.
//  2 Decimation: in_data=0x00100 every cycle, out_ready=1 -> out_data=0x001, one output per
//    4 inputs, first out_valid 2 edges after the 4th input edge.
//  3 Saturation: in_data=0x7FFFF -> 0x7FF; in_data=0x80000 -> 0x800; 0x7FF00 -> 0x7FF.
//  4 Rounding: 0x00180 -> 0x002 (ROUND_EN) / 0x001 (not); 0xFFE80 -> 0xFFF (ROUND_EN) / 0xFFE (not).
//  5 Full: out_ready=0, push 9 decimated values 1..9 -> level=8, drop=1; drain -> 1..8 in order;
//    then push at full with out_ready=1 -> accepted, level stays 8; drop_clr -> drop=0.
//  6 Mid-op reset: level=5, RSTN low between edges -> out_valid=0, level=0 at once; after
//    release, next output only after 4 further in_valid cycles (phase restarted).

Source files
------------

// File: rtl/fir_decim_requant.sv
// Decimating requantiser behind the 63-tap FIR: keeps every DECIM-th sample, shifts and saturates
// it to OUT_W bits and queues it in a show-ahead FIFO. Define FIR_DECIM_ROUND_EN for round-half-up.
module fir_decim_requant #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 12,
    parameter int SHIFT = 8,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop,
    input  logic                       drop_clr
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = (IN_W + 1)'(-(1 << (OUT_W - 1)));
`ifdef FIR_DECIM_ROUND_EN
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_W:0] RND = (SHIFT > 0) ? (IN_W + 1)'(1 << RND_POS) : '0;
`else
    localparam logic signed [IN_W:0] RND = '0;
`endif

    logic [PW-1:0]          phase;
    logic                   take;
    logic                   s0_valid;
    logic [IN_W-1:0]        s0_data;
    logic                   s1_valid;
    logic [OUT_W-1:0]       s1_q;
    logic signed [IN_W:0]   ext;
    logic signed [IN_W:0]   sum;
    logic signed [IN_W:0]   shifted;
    logic [OUT_W-1:0]       q_sat;

    logic [OUT_W-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic                   full;
    logic                   pop;
    logic                   push_ok;
    logic                   drop_set;

    assign take = in_valid && (phase == PHASE_LAST);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            phase    <= '0;
            s0_valid <= 1'b0;
            s0_data  <= '0;
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (in_valid) begin
                phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            end
            s0_valid <= take;
            if (take) begin
                s0_data <= in_data;
            end
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_q <= q_sat;
            end
        end
    end

    // One extra bit of headroom keeps the rounding add from wrapping before saturation.
    always_comb begin
        ext     = {s0_data[IN_W-1], s0_data};
        sum     = ext + RND;
        shifted = sum >>> SHIFT;
        if (shifted > SAT_MAX) begin
            q_sat = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            q_sat = SAT_MIN[OUT_W-1:0];
        end else begin
            q_sat = shifted[OUT_W-1:0];
        end
    end

    // Sink handshake: an entry leaves on any edge where out_valid && out_ready; out_data is the
    // head entry, stable while out_valid is high and not popped. A full FIFO still takes a push
    // when a pop happens on the same edge; otherwise the push is lost and drop is set.
    assign full      = (count == COUNT_FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = s1_valid && (!full || pop);
    assign drop_set  = s1_valid && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign level     = count;

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= s1_q;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop_set) begin
                drop <= 1'b1;
            end else if (drop_clr) begin
                drop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed bench for fir_decim_requant at default parameters; expectations follow the
// FIR_DECIM_ROUND_EN setting of the build.
module tb_fir_decim_requant;

    localparam int IN_W  = 20;
    localparam int OUT_W = 12;

    logic              CLK;
    logic              RSTN;
    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              out_ready;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic [3:0]        level;
    logic              drop;
    logic              drop_clr;

    int tests;
    int fails;
    logic [OUT_W-1:0] exp_q[$];

    fir_decim_requant dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .drop      (drop),
        .drop_clr  (drop_clr)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // drivers: one full decimation group whose sampled word is d
    task automatic send(input logic [IN_W-1:0] d);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = d;
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic pop_check(input string tag, input logic [OUT_W-1:0] expv);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(expv));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [OUT_W-1:0] e;
        tests     = 0;
        fails     = 0;
        RSTN      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        drop_clr  = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = IN_W'($urandom_range(0, 20'hFFFFF));
            out_ready = 1'($urandom_range(0, 1));
            drop_clr  = 1'($urandom_range(0, 1));
            tick();
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_level", 32'(level), 32'd0);
            chk("rst_drop", 32'(drop), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
        end
        RSTN      = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        drop_clr  = 1'b0;

        // 2: decimation and latency, sink always ready
        in_valid  = 1'b1;
        in_data   = 20'h00100;
        out_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 6 || k == 10) begin
                chk("dec_valid", 32'(out_valid), 32'd1);
                chk("dec_level", 32'(level), 32'd1);
                chk("dec_data", 32'(out_data), 32'h001);
            end else begin
                chk("dec_idle", 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("dec_flush", 32'(level), 32'd0);
        out_ready = 1'b0;

        // 3: saturation
        send(20'h7FFFF);
        send(20'h80000);
        send(20'h7FF00);
        tick();
        tick();
        chk("sat_level", 32'(level), 32'd3);
        pop_check("sat_pos_max", 12'h7FF);
        pop_check("sat_neg_max", 12'h800);
        pop_check("sat_7ff00", 12'h7FF);
        chk("sat_empty", 32'(level), 32'd0);

        // 4: rounding vs truncation
        send(20'h00180);
        send(20'hFFE80);
        tick();
        tick();
`ifdef FIR_DECIM_ROUND_EN
        pop_check("rnd_pos", 12'h002);
        pop_check("rnd_neg", 12'hFFF);
`else
        pop_check("rnd_pos", 12'h001);
        pop_check("rnd_neg", 12'hFFE);
`endif

        // 5: full FIFO, drop, push-with-pop at full, drop_clr
        for (int k = 1; k <= 9; k++) begin
            send(IN_W'(k << 8));
            if (k <= 8) exp_q.push_back(OUT_W'(k));
        end
        tick();
        tick();
        chk("full_level", 32'(level), 32'd8);
        chk("full_drop", 32'(drop), 32'd1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_check("full_drain", e);
        end
        chk("drain_level", 32'(level), 32'd0);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        chk("drop_clr", 32'(drop), 32'd0);
        for (int k = 10; k <= 17; k++) send(IN_W'(k << 8));
        tick();
        tick();
        chk("refill_level", 32'(level), 32'd8);
        send(IN_W'(18 << 8));
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pushpop_level", 32'(level), 32'd8);
        chk("pushpop_drop", 32'(drop), 32'd0);
        send(IN_W'(19 << 8));
        tick();
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        chk("set_wins_drop", 32'(drop), 32'd1);
        chk("set_wins_level", 32'(level), 32'd8);
        for (int k = 11; k <= 18; k++) exp_q.push_back(OUT_W'(k));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_check("full_drain2", e);
        end
        chk("drain2_level", 32'(level), 32'd0);

        // 6: reset in the middle of operation
        for (int k = 1; k <= 5; k++) send(IN_W'(k << 8));
        tick();
        tick();
        chk("mid_level", 32'(level), 32'd5);
        in_valid = 1'b1;
        in_data  = 20'h00300;
        tick();
        tick();
        #3;
        RSTN = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        tick();
        RSTN      = 1'b1;
        in_valid  = 1'b1;
        in_data   = 20'h00100;
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("restart_valid", 32'(out_valid), (k == 6) ? 32'd1 : 32'd0);
        end
        chk("restart_data", 32'(out_data), 32'h001);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
